// File: rtl/conv_accumulator.sv
// Saturating accumulator: sums TAPS signed products per window, result presented on a registered valid/ready port.
// Result appears one cycle after the last tap is accepted; input stalls only when the last tap would overwrite an unaccepted result.
module conv_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int TAPS   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]        sum_q, sum_d;
  logic                    sum_ovf_q, sum_ovf_d;
  logic                    vld_q, vld_d;

  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W:0]   nxt;
  logic signed [ACC_W-1:0] res;
  logic                    sat_pos, sat_neg, sat;
  logic                    last_tap, take, fire;

  assign p_ext = ACC_W'($signed(product));
  // One guard bit: the sum of two ACC_W values always fits in ACC_W+1.
  assign nxt     = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
  assign sat_pos = !nxt[ACC_W] && nxt[ACC_W-1];
  assign sat_neg = nxt[ACC_W] && !nxt[ACC_W-1];
  assign sat     = sat_pos || sat_neg;
  assign res     = sat_pos ? {1'b0, {(ACC_W-1){1'b1}}} :
                   sat_neg ? {1'b1, {(ACC_W-1){1'b0}}} : nxt[ACC_W-1:0];

  assign last_tap = (cnt_q == LAST);
  assign in_ready = !(last_tap && vld_q && !out_ready);
  assign take     = in_valid && in_ready && !flush;
  assign fire     = vld_q && out_ready;

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    vld_d     = vld_q && !fire;
    if (flush) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (take) begin
      if (last_tap) begin
        acc_d     = '0;
        ovf_d     = 1'b0;
        cnt_d     = '0;
        sum_d     = res;
        sum_ovf_d = ovf_q || sat;
        vld_d     = 1'b1;
      end else begin
        acc_d = res;
        ovf_d = ovf_q || sat;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
      vld_q     <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_ovf   = sum_ovf_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: default 9-tap instance plus a narrow 2-tap instance for saturation.
module tb_conv_accumulator;

  localparam int TA_TAPS = 9;
  localparam int TA_ACCW = 20;
  localparam int TB_TAPS = 2;
  localparam int TB_ACCW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                      a_flush, a_vld, a_rdy, a_ovld, a_ordy, a_ovf;
  logic signed [15:0]        a_prod;
  logic signed [TA_ACCW-1:0] a_sum;
  logic                      b_flush, b_vld, b_rdy, b_ovld, b_ordy, b_ovf;
  logic signed [15:0]        b_prod;
  logic signed [TB_ACCW-1:0] b_sum;

  conv_accumulator #(.PROD_W(16), .ACC_W(TA_ACCW), .TAPS(TA_TAPS)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_vld), .in_ready(a_rdy),
    .product(a_prod), .out_valid(a_ovld), .out_ready(a_ordy), .out_sum(a_sum), .out_ovf(a_ovf));

  conv_accumulator #(.PROD_W(16), .ACC_W(TB_ACCW), .TAPS(TB_TAPS)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_vld), .in_ready(b_rdy),
    .product(b_prod), .out_valid(b_ovld), .out_ready(b_ordy), .out_sum(b_sum), .out_ovf(b_ovf));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Saturating running sum over a whole window, clamped after every tap.
  function automatic void fold(input longint q[$], input int aw, output longint s, output bit o);
    longint mx, mn;
    mx = (longint'(1) << (aw - 1)) - 1;
    mn = -mx - 1;
    s = 0;
    o = 1'b0;
    foreach (q[i]) begin
      s = s + q[i];
      if (s > mx) begin s = mx; o = 1'b1; end
      else if (s < mn) begin s = mn; o = 1'b1; end
    end
  endfunction

  longint qa[$], qb[$];
  bit     ma_vld, mb_vld, ma_ovf, mb_ovf;
  longint ma_sum, mb_sum;

  function automatic bit exp_rdy_a();
    return !(qa.size() == TA_TAPS - 1 && ma_vld && !a_ordy);
  endfunction
  function automatic bit exp_rdy_b();
    return !(qb.size() == TB_TAPS - 1 && mb_vld && !b_ordy);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_a
    bit done;
    done = 1'b0;
    if (!rst_n) begin
      qa.delete(); ma_vld = 1'b0; ma_sum = 0; ma_ovf = 1'b0;
    end else begin
      if (a_flush) qa.delete();
      else if (a_vld && exp_rdy_a()) begin
        qa.push_back(longint'(a_prod));
        if (qa.size() == TA_TAPS) begin
          fold(qa, TA_ACCW, ma_sum, ma_ovf);
          qa.delete();
          done = 1'b1;
        end
      end
      if (done) ma_vld = 1'b1;
      else if (a_ordy) ma_vld = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin : model_b
    bit done;
    done = 1'b0;
    if (!rst_n) begin
      qb.delete(); mb_vld = 1'b0; mb_sum = 0; mb_ovf = 1'b0;
    end else begin
      if (b_flush) qb.delete();
      else if (b_vld && exp_rdy_b()) begin
        qb.push_back(longint'(b_prod));
        if (qb.size() == TB_TAPS) begin
          fold(qb, TB_ACCW, mb_sum, mb_ovf);
          qb.delete();
          done = 1'b1;
        end
      end
      if (done) mb_vld = 1'b1;
      else if (b_ordy) mb_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("a_in_ready", a_rdy, exp_rdy_a());
    chk("a_out_valid", a_ovld, ma_vld);
    if (ma_vld) begin
      chk("a_out_sum", a_sum, ma_sum);
      chk("a_out_ovf", a_ovf, ma_ovf);
    end
    chk("b_in_ready", b_rdy, exp_rdy_b());
    chk("b_out_valid", b_ovld, mb_vld);
    if (mb_vld) begin
      chk("b_out_sum", b_sum, mb_sum);
      chk("b_out_ovf", b_ovf, mb_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    a_flush = 0; a_vld = 0; a_prod = 0; a_ordy = 1;
    b_flush = 0; b_vld = 0; b_prod = 0; b_ordy = 1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_rdy", a_rdy, 1); chk("rst_a_vld", a_ovld, 0);
    chk("rst_a_sum", a_sum, 0); chk("rst_b_vld", b_ovld, 0);
    #9 rst_n = 1'b1;
    step();

    // Basic windows back-to-back
    a_vld = 1;
    for (int i = 1; i <= 9; i++) begin a_prod = 16'(i); step(); end
    chk("basic_vld", a_ovld, 1); chk("basic_sum", a_sum, 45); chk("basic_ovf", a_ovf, 0);
    for (int i = 0; i < 9; i++) begin a_prod = -16'sd16384; step(); end
    chk("neg_sum", a_sum, -147456); chk("neg_ovf", a_ovf, 0);
    a_vld = 0; step();

    // Backpressure: second window's last tap stalls behind the unaccepted first result
    a_vld = 1; a_prod = 1;
    for (int i = 0; i < 9; i++) step();
    a_ordy = 0;
    for (int i = 0; i < 8; i++) step();
    chk("bp_stall_rdy", a_rdy, 0); chk("bp_hold_sum", a_sum, 9);
    step(); step();
    chk("bp_still_vld", a_ovld, 1); chk("bp_still_sum", a_sum, 9);
    a_ordy = 1; step();
    a_ordy = 0; a_vld = 0;
    chk("bp_reload_vld", a_ovld, 1); chk("bp_reload_sum", a_sum, 9); chk("bp_rdy_back", a_rdy, 1);
    a_ordy = 1; step();

    // Flush leaves a pending result alone and drops the partial window plus its same-cycle product
    a_vld = 1; a_prod = 3;
    for (int i = 0; i < 9; i++) step();
    a_ordy = 0; a_prod = 100;
    for (int i = 0; i < 4; i++) step();
    a_prod = 7; a_flush = 1; step();
    a_flush = 0;
    chk("flush_keep_vld", a_ovld, 1); chk("flush_keep_sum", a_sum, 27);
    a_ordy = 1; a_prod = 1;
    for (int i = 0; i < 9; i++) step();
    chk("flush_sum", a_sum, 9); chk("flush_ovf", a_ovf, 0);
    a_vld = 0; step();

    // Saturation on the narrow instance, sticky flag cleared per window
    b_vld = 1; b_prod = 16384; step(); step();
    chk("sat_pos_sum", b_sum, 32767); chk("sat_pos_ovf", b_ovf, 1);
    b_prod = 5; step(); b_prod = -3; step();
    chk("sat_clr_sum", b_sum, 2); chk("sat_clr_ovf", b_ovf, 0);
    b_prod = -16'sd32768; step(); b_prod = -1; step();
    chk("sat_neg_sum", b_sum, -32768); chk("sat_neg_ovf", b_ovf, 1);
    b_vld = 0; step();

    // Asynchronous reset with a pending result and a partial window
    a_vld = 1; a_ordy = 0; a_prod = 50;
    for (int i = 0; i < 12; i++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", a_ovld, 0); chk("arst_sum", a_sum, 0);
    chk("arst_rdy", a_rdy, 1); chk("arst_ovf", a_ovf, 0);
    a_vld = 0; a_ordy = 1;
    step();
    #2 rst_n = 1'b1;
    step();
    a_vld = 1; a_prod = 2;
    for (int i = 0; i < 8; i++) step();
    chk("post_rst_idle", a_ovld, 0);
    step();
    chk("post_rst_sum", a_sum, 18);
    a_vld = 0; step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Sequential accumulate stage that sits directly downstream of the signed 8x8 Booth multiplier in the convolution datapath. Accepts one 16-bit signed product per cycle over a valid/ready handshake, sums TAPS consecutive products into one convolution output pixel, and presents the saturated sum on a registered valid/ready output port. Back-to-back windows stream without bubbles; a partial window can be discarded with a synchronous flush.

## Interface
- PROD_W, 16: width of the signed product input (multiplier output width).
- ACC_W, 20: width of the signed accumulator and of the output sum; must be ≥ PROD_W.
- TAPS, 9: products per window (3x3 kernel); legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards the partial window in progress.
- in_valid  input  1  product is valid this cycle.
- in_ready  output  1  stage can accept a product this cycle.
- product  input  PROD_W  signed product from the multiplier.
- out_valid  output  1  out_sum/out_ovf hold a completed window.
- out_ready  input  1  downstream accepts the result this cycle.
- out_sum  output  ACC_W  signed saturated window sum.
- out_ovf  output  1  saturation occurred at least once in this window.

## Operation
- Input transfer: in_valid && in_ready at a rising clk edge. Output transfer: out_valid && out_ready.
- Internal state: acc (ACC_W signed), ovf (sticky), tap counter cnt (0..TAPS-1), output register {out_sum, out_ovf, out_valid}.
- Each input transfer: p = sign-extend(product) to ACC_W; nxt = acc + p computed at ACC_W+1 bits; if nxt > 2^(ACC_W-1)-1 result = max positive and ovf set; if nxt < -2^(ACC_W-1) result = max negative and ovf set; else result = nxt.
- cnt < TAPS-1: acc <= result, cnt <= cnt+1.
- cnt == TAPS-1 (last tap): out_sum <= result, out_ovf <= ovf | (saturation this tap), out_valid <= 1; acc <= 0, ovf <= 0, cnt <= 0. The next window starts on the following transfer.
- in_ready = !(cnt == TAPS-1 && out_valid && !out_ready); stalls only when the last tap would overwrite an unaccepted result. in_ready is combinational from out_valid, out_ready and cnt, never from in_valid.
- Output transfer with no simultaneous last tap: out_valid <= 0; out_sum/out_ovf hold their value.
- Output transfer and last-tap transfer in the same cycle: new result loads, out_valid stays 1.
- While out_valid && !out_ready, out_sum and out_ovf are stable.
- flush: acc <= 0, ovf <= 0, cnt <= 0; any product transferred in the same cycle is discarded; the output register and out_valid are untouched. flush has priority over accumulation.
- TAPS == 1: every accepted product becomes a result directly (saturated to ACC_W).

## Timing
- Reset (rst_n low, asynchronous): acc = 0, ovf = 0, cnt = 0, out_valid = 0, out_sum = 0, out_ovf = 0; in_ready = 1 immediately. Deassertion is synchronous to clk by the surrounding reset logic.
- Reset mid-window discards the partial sum and any pending result; no output is produced for that window.
- Latency: out_valid rises on the clock edge that accepts the last tap, one cycle after that tap is presented.
- Throughput: one product per cycle with out_ready held high; one result per TAPS cycles; no dead cycle between windows.
- Stall: if the last tap arrives while a result is pending and out_ready is low, in_ready is low. The tap is held upstream and accepted in the first cycle out_ready is high.

## Test plan
- Reset/idle: assert rst_n low mid-stream -> all outputs 0 and in_ready 1 asynchronously; no out_valid until TAPS new products are accepted.
- Basic window: TAPS=9, out_ready=1, products 1,2,...,9 back-to-back -> one cycle after the 9th, out_valid=1, out_sum=45, out_ovf=0; the next window of nine -16384 values gives out_sum=-147456 with no bubble.
- Saturation: ACC_W=16, TAPS=2, products 16384, 16384 -> out_sum=32767, out_ovf=1; the following window 5, -3 -> out_sum=2, out_ovf=0 (sticky flag cleared).
- Backpressure: out_ready=0 after the first result, keep streaming 18 products of value 1 -> in_ready drops at tap 9 of the second window and out_sum stays 9. Raise out_ready for one cycle -> the pending 9 transfers and the second result 9 loads in the same edge with out_valid remaining 1.
- Flush: feed 4 products of 100, assert flush with in_valid=1 and product=7, then feed 9 products of 1 -> out_sum=9; the earlier result in the output register is unchanged by the flush.
